// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state encoding, opcodes and default widths for the instruction sequencer
package instr_sequencer_pkg;

    localparam int N_DEFAULT        = 8;
    localparam int AW_DEFAULT       = 5;
    localparam int PROG_LEN_DEFAULT = 32;
    localparam int WDT_DEFAULT      = 7;

    localparam logic [1:0] OP_MVI = 2'b00;
    localparam logic [1:0] OP_CPY = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_IMM,
        ST_ISSUE,
        ST_WAIT,
        ST_PAUSE,
        ST_HALT,
        ST_ERROR
    } seq_state_e;

    function automatic logic is_mvi(input logic [1:0] opcode);
        return opcode == OP_MVI;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating wait counter that flags the last permitted cycle without done
module seq_watchdog
    import instr_sequencer_pkg::*;
#(
    parameter int WDT = WDT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW       = $clog2(WDT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WDT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WDT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Expires while the WDT-th waiting cycle is in progress, so the error lands exactly WDT cycles in.
    assign expire_o = enable_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches program words, issues them to the control unit and tracks completion
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int PROG_LEN = PROG_LEN_DEFAULT,
    parameter int WDT      = WDT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_data,
    output logic [N-1:0]  instruction,
    output logic [N-1:0]  imm_data,
    output logic          run,
    input  logic          done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          error
);

    // One extra bit so PROG_LEN = 2^AW and pc overflow are representable.
    localparam logic [AW:0] LEN = (AW + 1)'(PROG_LEN);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0]  instr_q, instr_d;
    logic [N-1:0]  imm_q, imm_d;
    logic          run_q, busy_q, halted_q, error_q;
    logic          wdt_expire;
    logic [AW:0]   pc_next_word;
    logic [AW:0]   pc_adv;

    assign pc_next_word = {1'b0, pc_q} + (AW + 1)'(1);
    assign pc_adv       = {1'b0, pc_q} +
                          (is_mvi(instr_q[N-1 -: 2]) ? (AW + 1)'(2) : (AW + 1)'(1));

    seq_watchdog #(
        .WDT(WDT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == ST_ISSUE),
        .enable_i (state_q == ST_WAIT),
        .expire_o (wdt_expire)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                // Present the following word early so an mvi immediate arrives in IMM.
                mem_addr_d = pc_next_word[AW-1:0];
                state_d    = ST_LATCH;
            end
            ST_LATCH: begin
                instr_d = mem_data;
                if (is_mvi(mem_data[N-1 -: 2])) begin
                    state_d = (pc_next_word >= LEN) ? ST_ERROR : ST_IMM;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_IMM: begin
                imm_d   = mem_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    if (pc_adv >= LEN) begin
                        state_d = ST_HALT;
                        pc_d    = pc_adv[AW] ? '1 : pc_adv[AW-1:0];
                    end else begin
                        pc_d    = pc_adv[AW-1:0];
                        state_d = step_mode ? ST_PAUSE : ST_FETCH;
                    end
                end else if (wdt_expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_FETCH) begin
            mem_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            imm_q      <= imm_d;
            run_q      <= (state_d == ST_ISSUE);
            busy_q     <= !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ERROR));
            halted_q   <= (state_d == ST_HALT);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    assign mem_addr    = mem_addr_q;
    assign instruction = instr_q;
    assign imm_data    = imm_q;
    assign run         = run_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for the instruction sequencer
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int N    = 8;
    localparam int AW   = 5;
    localparam int PLEN = 3;
    localparam int WDT  = 7;
    localparam int AWB  = 3;
    localparam int PLENB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, step_mode_a = 1'b0, step_a = 1'b0, done_a;
    logic [AW-1:0] mem_addr_a, pc_a;
    logic [N-1:0]  mem_data_a, instr_a, imm_a;
    logic          run_a, busy_a, halted_a, error_a;

    logic           start_b = 1'b0, done_b;
    logic [AWB-1:0] mem_addr_b, pc_b;
    logic [N-1:0]   mem_data_b, instr_b, imm_b;
    logic           run_b, busy_b, halted_b, error_b;

    logic [N-1:0] mem_a [0:31];
    logic [N-1:0] mem_b [0:7];

    always #5 clk = ~clk;

    always @(posedge clk) mem_data_a <= mem_a[mem_addr_a];
    always @(posedge clk) mem_data_b <= mem_b[mem_addr_b];

    instr_sequencer #(.N(N), .AW(AW), .PROG_LEN(PLEN), .WDT(WDT)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .step_mode(step_mode_a), .step(step_a),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a), .instruction(instr_a), .imm_data(imm_a),
        .run(run_a), .done(done_a), .pc(pc_a), .busy(busy_a), .halted(halted_a), .error(error_a)
    );

    instr_sequencer #(.N(N), .AW(AWB), .PROG_LEN(PLENB), .WDT(WDT)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .step_mode(1'b0), .step(1'b0),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .instruction(instr_b), .imm_data(imm_b),
        .run(run_b), .done(done_b), .pc(pc_b), .busy(busy_b), .halted(halted_b), .error(error_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [AW-1:0] pc;
        logic [N-1:0]  instr;
        logic [N-1:0]  imm;
        bit            chk_imm;
    } exp_t;

    exp_t           sb[$];
    logic [AWB-1:0] sb_b[$];
    int  runs_a = 0;
    int  runs_b = 0;
    int  done_timer = 0;
    bit  auto_done = 1'b1;
    bit  late_done = 1'b0;
    bit  run_b_seen = 1'b0;

    // Responder and scoreboard consumer for dut_a: done two cycles after each run.
    always @(negedge clk) begin
        exp_t e;
        done_a = late_done;
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) done_a = 1'b1;
        end
        if (run_a) begin
            runs_a++;
            if (sb.size() == 0) begin
                check("a_spurious_run", 32'(run_a), 32'd0);
            end else begin
                e = sb.pop_front();
                check("a_run_pc", 32'(pc_a), 32'(e.pc));
                check("a_run_instr", 32'(instr_a), 32'(e.instr));
                if (e.chk_imm) check("a_run_imm", 32'(imm_a), 32'(e.imm));
            end
            if (auto_done) done_timer = 2;
        end
    end

    // dut_b answers one cycle after each run.
    always @(negedge clk) begin
        done_b = run_b_seen;
        run_b_seen = run_b;
        if (run_b) begin
            runs_b++;
            if (sb_b.size() == 0) check("b_spurious_run", 32'(run_b), 32'd0);
            else check("b_run_pc", 32'(pc_b), 32'(sb_b.pop_front()));
        end
    end

    // Reference walk of the program in mem_a: which words run and whether it ends in error.
    task automatic load_expect(input int plen, output bit exp_err);
        int p;
        logic [N-1:0] w;
        p = 0;
        exp_err = 1'b0;
        sb.delete();
        while (p < plen) begin
            w = mem_a[p];
            if (w[N-1:N-2] == 2'b00) begin
                if (p + 1 >= plen) begin
                    exp_err = 1'b1;
                    break;
                end
                sb.push_back('{pc: AW'(p), instr: w, imm: mem_a[p+1], chk_imm: 1'b1});
                p += 2;
            end else begin
                sb.push_back('{pc: AW'(p), instr: w, imm: '0, chk_imm: 1'b0});
                p += 1;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_runs(input int target, input string tag);
        int k;
        k = 0;
        while (runs_a < target && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_run_seen"}, 32'(runs_a >= target), 32'd1);
    endtask

    task automatic wait_stop(input string tag);
        int k;
        k = 0;
        while (!(halted_a || error_a) && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_stopped"}, 32'(halted_a || error_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  base;
        bit  exp_err;
        for (int i = 0; i < 32; i++) mem_a[i] = '0;
        for (int i = 0; i < 8; i++) mem_b[i] = 8'h40 | 8'(i);

        tick(2);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_halted", 32'(halted_a), 32'd0);
        check("rst_error", 32'(error_a), 32'd0);
        check("rst_run", 32'(run_a), 32'd0);
        check("rst_pc", 32'(pc_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_instr", 32'(instr_a), 32'd0);
        check("rst_imm", 32'(imm_a), 32'd0);
        rst = 1'b0;
        tick();

        // mvi R0,#5 ; add R0,R1
        mem_a[0] = 8'h00; mem_a[1] = 8'h05; mem_a[2] = 8'h81;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        check("t1_busy_after_start", 32'(busy_a), 32'd1);
        wait_runs(base + 1, "t1");
        check("t1_imm_in_wait", 32'(imm_a), 32'd5);
        wait_stop("t1");
        check("t1_halted", 32'(halted_a), 32'd1);
        check("t1_error", 32'(error_a), 32'd0);
        check("t1_busy", 32'(busy_a), 32'd0);
        check("t1_pc_end", 32'(pc_a), 32'd3);
        check("t1_runs", 32'(runs_a - base), 32'd2);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Step mode over three cpy words.
        mem_a[0] = 8'h40; mem_a[1] = 8'h41; mem_a[2] = 8'h42;
        step_mode_a = 1'b1;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_runs(base + i + 1, "t2");
            step_a = 1'b1;
            tick();
            step_a = 1'b0;
            tick(8);
            check("t2_runs_per_step", 32'(runs_a - base), 32'(i + 1));
            if (i < 2) begin
                check("t2_paused_busy", 32'(busy_a), 32'd1);
                step_a = 1'b1;
                tick();
                step_a = 1'b0;
            end
        end
        wait_stop("t2");
        check("t2_halted", 32'(halted_a), 32'd1);
        check("t2_pc_end", 32'(pc_a), 32'd3);
        step_mode_a = 1'b0;

        // Watchdog: done withheld.
        auto_done = 1'b0;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        check("t3_pc_restart", 32'(pc_a), 32'd0);
        wait_runs(base + 1, "t3");
        tick(WDT - 1);
        check("t3_error_early", 32'(error_a), 32'd0);
        tick();
        check("t3_error_on_time", 32'(error_a), 32'd1);
        check("t3_busy", 32'(busy_a), 32'd0);
        check("t3_halted", 32'(halted_a), 32'd0);
        auto_done = 1'b1;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        check("t3_recover_pc", 32'(pc_a), 32'd0);
        check("t3_recover_busy", 32'(busy_a), 32'd1);
        wait_stop("t3");
        check("t3_recover_halted", 32'(halted_a), 32'd1);
        check("t3_recover_runs", 32'(runs_a - base), 32'd3);

        // mvi in the last program word.
        mem_a[0] = 8'h40; mem_a[1] = 8'h41; mem_a[2] = 8'h00;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        wait_stop("t4");
        tick(5);
        check("t4_error", 32'(error_a), 32'(exp_err));
        check("t4_halted", 32'(halted_a), 32'd0);
        check("t4_runs", 32'(runs_a - base), 32'd2);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_pc", 32'(pc_a), 32'd2);

        // Asynchronous reset in WAIT, then a late done.
        mem_a[2] = 8'h42;
        auto_done = 1'b0;
        load_expect(PLEN, exp_err);
        base = runs_a;
        pulse_start();
        wait_runs(base + 1, "t5");
        tick();
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_pc", 32'(pc_a), 32'd0);
        check("t5_mem_addr", 32'(mem_addr_a), 32'd0);
        check("t5_instr", 32'(instr_a), 32'd0);
        check("t5_imm", 32'(imm_a), 32'd0);
        check("t5_run", 32'(run_a), 32'd0);
        check("t5_halted", 32'(halted_a), 32'd0);
        check("t5_error", 32'(error_a), 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        base = runs_a;
        late_done = 1'b1;
        tick();
        late_done = 1'b0;
        tick(10);
        check("t5_no_run_after_rst", 32'(runs_a - base), 32'd0);
        check("t5_idle_busy", 32'(busy_a), 32'd0);
        check("t5_idle_error", 32'(error_a), 32'd0);

        // Full 2^AW program on dut_b.
        for (int i = 0; i < PLENB; i++) sb_b.push_back(AWB'(i));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            int k;
            k = 0;
            while (!(halted_b || error_b) && k < 300) begin
                tick();
                k++;
            end
        end
        tick(5);
        check("t6_halted", 32'(halted_b), 32'd1);
        check("t6_error", 32'(error_b), 32'd0);
        check("t6_runs", 32'(runs_b), 32'(PLENB));
        check("t6_pc_no_wrap", 32'(pc_b != '0), 32'd1);
        check("t6_sb_empty", 32'(sb_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter N, default 8, instruction/data word width.
REQ-002 Parameter AW, default 5, program address width.
REQ-003 Parameter PROG_LEN, default 32, number of valid program words, 1..2^AW.
REQ-004 Parameter WDT, default 7, maximum cycles to wait for done before error.
REQ-005 clk  in  1  single clock, all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  level; sampled in IDLE; begins execution at address 0.
REQ-008 step_mode  in  1  1 = pause after each instruction until step.
REQ-009 step  in  1  single-cycle pulse; releases one instruction in step mode.
REQ-010 mem_addr  out  AW  synchronous program memory read address.
REQ-011 mem_data  in  N  memory read data, valid the cycle after mem_addr is driven.
REQ-012 instruction  out  N  held instruction word to control unit.
REQ-013 imm_data  out  N  immediate operand for mvi, drives datapath external input.
REQ-014 run  out  1  one-cycle pulse starting the control unit.
REQ-015 done  in  1  control-unit completion strobe.
REQ-016 pc  out  AW  address of the instruction currently held.
REQ-017 busy  out  1  high in every state except IDLE, HALT and ERROR.
REQ-018 halted  out  1  high in HALT; error  out  1  high in ERROR.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, LATCH, IMM, ISSUE, WAIT, PAUSE, HALT, ERROR.
REQ-020 IDLE: start=1 -> pc=0, FETCH; else stay.
REQ-021 FETCH: mem_addr=pc; next LATCH (one-cycle memory latency).
REQ-022 LATCH: instruction<=mem_data; opcode [N-1:N-2]=00 (mvi) -> mem_addr=pc+1, IMM; else ISSUE.
REQ-023 IMM: imm_data<=mem_data; next ISSUE.
REQ-024 ISSUE: run=1 for exactly this cycle; watchdog cleared; next WAIT.
REQ-025 WAIT: done=1 -> advance pc by 2 for mvi, 1 otherwise; then PAUSE if step_mode else FETCH.
REQ-026 Advanced pc >= PROG_LEN -> HALT instead of FETCH/PAUSE; no wrap-around of pc.
REQ-027 mvi at pc=PROG_LEN-1 (immediate out of range) -> ERROR from LATCH, run never pulsed.
REQ-028 WAIT: watchdog counts cycles; done absent after WDT cycles -> ERROR.
REQ-029 PAUSE: step=1 -> FETCH; step during any other state SHALL be ignored.
REQ-030 step_mode deasserted while in PAUSE -> FETCH next cycle.
REQ-031 HALT, ERROR: sticky; leave only on start=1 -> pc=0, FETCH.
REQ-032 done outside WAIT SHALL be ignored; done in same cycle as ISSUE not counted.
REQ-033 instruction and imm_data SHALL be stable from ISSUE until the next LATCH.
REQ-034 Watchdog counter width SHALL be clog2(WDT+1); saturates, never wraps.

Reset
REQ-035 rst=1 SHALL force IDLE, pc=0, mem_addr=0, instruction=0, imm_data=0, run=0, busy=0, halted=0, error=0, watchdog=0, immediately and asynchronously.
REQ-036 rst mid-instruction SHALL abandon it; no run pulse after release until start.

Structure
REQ-037 Shared package: state encoding, opcode constants (MVI=00, CPY=01, ADD=10, SUB=11), default widths.
REQ-038 One sub-module, seq_watchdog (saturating counter, clear/enable, timeout flag); FSM and pc stay in top.

Verification
REQ-039 Program {mvi R0,#5 ; add R0,R1}, done 2 cycles after each run -> run pulses 2, pc 0->2->3, imm_data=5 during first WAIT, HALT with PROG_LEN=3.
REQ-040 step_mode=1, 3 cpy words -> exactly one run per step pulse; extra step during WAIT ignored.
REQ-041 done withheld after run -> error=1 exactly WDT cycles after WAIT entry; start recovers to pc=0.
REQ-042 mvi placed at PROG_LEN-1 -> ERROR, run never asserted for it.
REQ-043 rst asserted in WAIT -> all outputs zero same cycle; late done after release ignored.
REQ-044 PROG_LEN=2^AW full program -> HALT after last word, pc never wraps to 0.
